// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads 1- or 2-byte instructions over req/ack, drives PC load strobes.
// Registered outputs except mem_addr (pass-through of addr_PC); decoder backpressure holds the instruction in HOLD.
module fetch_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_fetch,
  input  logic              rst_fetch,
  input  logic [ADDR_W-1:0] addr_PC,
  output logic              write_pc,
  output logic              PC_sel,
  output logic [ADDR_W-1:0] cBusData,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand
);

  typedef enum logic [2:0] {
    IDLE, REQ_OP, INC_OP, REQ_OPR, INC_OPR, HOLD, DRAIN, JUMP
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                write_pc_q, pc_sel_q, mem_req_q, ir_valid_q;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    target_d  = target_q;
    if (flush) target_d = flush_target;

    unique case (state_q)
      IDLE:    state_d = flush ? JUMP : REQ_OP;
      REQ_OP: begin
        // A flush with a same-cycle ack drops the returned byte
        if (flush)        state_d = mem_ack ? JUMP : DRAIN;
        else if (mem_ack) begin
          opcode_d = mem_rdata;
          state_d  = INC_OP;
        end
      end
      INC_OP: begin
        if (flush)            state_d = JUMP;
        else if (opcode_q[7]) state_d = REQ_OPR;
        else begin
          operand_d = '0;
          state_d   = HOLD;
        end
      end
      REQ_OPR: begin
        if (flush)        state_d = mem_ack ? JUMP : DRAIN;
        else if (mem_ack) begin
          operand_d = mem_rdata;
          state_d   = INC_OPR;
        end
      end
      INC_OPR: state_d = flush ? JUMP : HOLD;
      HOLD: begin
        if (flush)         state_d = JUMP;
        else if (ir_ready) state_d = REQ_OP;
      end
      DRAIN:   state_d = mem_ack ? JUMP : DRAIN;
      JUMP:    state_d = flush ? JUMP : REQ_OP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change together with the state flops
  always_ff @(posedge clk_fetch) begin
    if (rst_fetch) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      operand_q  <= '0;
      target_q   <= '0;
      write_pc_q <= 1'b0;
      pc_sel_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      target_q   <= target_d;
      write_pc_q <= (state_d == INC_OP) || (state_d == INC_OPR) || (state_d == JUMP);
      pc_sel_q   <= (state_d == JUMP);
      mem_req_q  <= (state_d == REQ_OP) || (state_d == REQ_OPR) || (state_d == DRAIN);
      ir_valid_q <= (state_d == HOLD);
    end
  end

  assign write_pc   = write_pc_q;
  assign PC_sel     = pc_sel_q;
  assign cBusData   = target_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_PC;
  assign ir_valid   = ir_valid_q;
  assign ir_opcode  = opcode_q;
  assign ir_operand = operand_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8-bit CPU. It reads the current program counter, fetches one- or two-byte instructions from program memory over a req/ack handshake, and presents them to the decoder. It drives the PC block's load controls: an increment after every fetched byte, and a target load on jump/flush. It sits between the PC block, program memory and the instruction decoder.

## Interface
- DATA_W, 8, instruction byte width (fixed at 8 for this CPU)
- ADDR_W, 8, program address width
- clk_fetch  in  1  clock; all logic on rising edge
- rst_fetch  in  1  synchronous, active-high reset
- addr_PC  in  ADDR_W  current PC value from the PC block
- write_pc  out  1  one-cycle load strobe to the PC block
- PC_sel  out  1  PC source select: 0 = increment, 1 = load cBusData
- cBusData  out  ADDR_W  jump target presented to the PC block
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address; equals addr_PC while mem_req=1
- mem_ack  in  1  memory read acknowledge; mem_rdata valid in the ack cycle
- mem_rdata  in  DATA_W  memory read data
- flush  in  1  one-cycle jump request from execute
- flush_target  in  ADDR_W  jump address, sampled with flush
- ir_valid  out  1  instruction available to decoder
- ir_ready  in  1  decoder accepts instruction
- ir_opcode  out  DATA_W  opcode byte
- ir_operand  out  DATA_W  operand byte; 0x00 for one-byte instructions

## Operation
- Format: opcode[7]=1 → two-byte instruction (opcode, operand); opcode[7]=0 → one byte.
- States: IDLE, REQ_OP, INC_OP, REQ_OPR, INC_OPR, HOLD, DRAIN, JUMP.
- IDLE: held during reset; at the first edge with rst_fetch=0 → REQ_OP.
- REQ_OP: mem_req=1. On mem_ack: capture mem_rdata into ir_opcode → INC_OP.
- INC_OP: write_pc=1, PC_sel=0 for one cycle → REQ_OPR if opcode[7], else ir_operand=0x00 → HOLD.
- REQ_OPR: mem_req=1. On mem_ack: capture ir_operand → INC_OPR.
- INC_OPR: write_pc=1, PC_sel=0 → HOLD.
- HOLD: ir_valid=1, ir_opcode/ir_operand stable. On ir_ready → REQ_OP.
- mem_req remains high and mem_addr stable until mem_ack is sampled. mem_req drops the cycle after the ack. write_pc never asserts while mem_req=1.
- Flush: latch flush_target.
  - In REQ_OP/REQ_OPR without a same-cycle ack → DRAIN. DRAIN holds mem_req until ack, discards the data, then → JUMP.
  - In any other state, or with a same-cycle ack (data discarded) → JUMP.
- JUMP: write_pc=1, PC_sel=1, cBusData=latched target for one cycle → REQ_OP.
- Flush in HOLD: ir_valid drops at the next edge. If ir_ready was also high in that cycle, the handshake counts as completed.
- Flush in JUMP or DRAIN: the new target replaces the latched one; JUMP repeats if already in JUMP.
- Flush in INC_*: the increment strobe in that cycle still occurs; JUMP follows and overrides it.
- PC wrap 0xFF→0x00 is handled by the PC block. A two-byte instruction at 0xFF takes its operand from 0x00.

## Timing
- Reset values: write_pc=0, PC_sel=0, cBusData=0x00, mem_req=0, ir_valid=0, ir_opcode=0x00, ir_operand=0x00, state=IDLE.
- Reset mid-operation: outputs return to reset values at the next edge. Any pending mem request is abandoned; memory must tolerate a dropped request.
- All outputs are registered except mem_addr, which is a direct pass of addr_PC.
- Zero-wait memory, one-byte instruction: REQ_OP, INC_OP, then ir_valid in the 3rd cycle.
- Zero-wait memory, two-byte instruction: ir_valid in the 5th cycle. Each memory wait cycle adds 1.
- After a HOLD handshake, mem_req rises in the next cycle.
- Flush to first new mem_req is 2 cycles (JUMP, then REQ_OP) when no access is outstanding.
- The PC updates at the end of each write_pc cycle. The next mem_addr reflects the new value.

## Test plan
- Reset: hold rst_fetch 3 cycles mid-fetch → all outputs at reset values. The first mem_req after release has mem_addr=0x00.
- One-byte, zero wait: mem[0x00]=0x12 → ir_valid in cycle 3, opcode 0x12, operand 0x00. Exactly one write_pc pulse with PC_sel=0; next mem_addr=0x01.
- Two-byte, 2 wait states per access: mem[0x01]=0x85, mem[0x02]=0x3C → opcode 0x85, operand 0x3C, two increment pulses, next mem_addr=0x03.
- Backpressure: ir_ready low for 4 cycles in HOLD → ir_valid/opcode/operand stable, mem_req=0, write_pc=0. ir_ready high → mem_req next cycle.
- Flush during wait: flush with target 0x40 while mem_req=1 and ack delayed 3 cycles → data discarded and no ir_valid. A single write_pc with PC_sel=1 and cBusData=0x40 follows; next mem_addr=0x40.
- Wrap: PC=0xFF, mem[0xFF]=0x90, mem[0x00]=0x07 → opcode 0x90, operand 0x07, next mem_addr=0x01.
